// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: default sample width, sample type,
// and the rounding offset used when dividing sums by a power of two.
package fir_pkg;

  localparam int unsigned DEFAULT_D_W = 12;

  typedef logic signed [DEFAULT_D_W-1:0] sample_t;

  // Half an LSB of the shifted result: adding it before >>> rounds half toward +inf.
  function automatic int unsigned round_offset(input int unsigned log2_decim);
    return 32'd1 << (log2_decim - 1);
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Show-ahead FIFO for decimated results. Pointers carry one extra MSB so that
// full and empty are distinguishable without a separate counter.
module fir_out_fifo #(
  parameter int unsigned D_W        = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PW        = $clog2(FIFO_DEPTH),
  localparam int unsigned LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  logic [D_W-1:0] wdata,
  input  logic           pop,
  output logic [D_W-1:0] rdata,
  output logic           full,
  output logic           empty,
  output logic [LW-1:0]  level
);

  logic [PW:0]    wptr, rptr;
  logic [D_W-1:0] mem [FIFO_DEPTH];
  logic           do_push, do_pop;

  // A push into a full FIFO is accepted only if the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[PW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PW+1)'(1);
      if (do_pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_decim_out.sv
// Integrate-and-dump decimator with round-half-up, feeding a show-ahead FIFO on a
// valid/ready output. Results dropped on overflow set a sticky ovf flag.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int unsigned D_W        = DEFAULT_D_W,
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic signed [D_W-1:0] dec_in,
  input  logic                  in_valid,
  output logic signed [D_W-1:0] dec_out,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [LW-1:0]         fifo_level,
  output logic                  ovf,
  input  logic                  clear_ovf
);

  localparam int unsigned AW = D_W + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] LastPhase = '1;
  localparam logic signed [AW-1:0] RoundOff = AW'(round_offset(LOG2_DECIM));

  logic [LOG2_DECIM-1:0] phase;
  logic signed [AW-1:0]  acc, sum_r, din_ext, rnd_sum;
  logic                  sum_v, res_v;
  logic signed [D_W-1:0] res_r;

  logic                  pop, full, empty, drop;
  logic [D_W-1:0]        head;

  assign din_ext = {{LOG2_DECIM{dec_in[D_W-1]}}, dec_in};
  assign rnd_sum = sum_r + RoundOff;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= '0;
      acc   <= '0;
      sum_r <= '0;
      sum_v <= 1'b0;
      res_r <= '0;
      res_v <= 1'b0;
    end else begin
      sum_v <= 1'b0;
      res_v <= sum_v;
      if (sum_v) res_r <= D_W'(rnd_sum >>> LOG2_DECIM);
      if (in_valid) begin
        phase <= phase + LOG2_DECIM'(1);
        // Phase 0 dumps: the previous group's total was already captured in sum_r.
        acc   <= (phase == '0) ? din_ext : acc + din_ext;
        if (phase == LastPhase) begin
          sum_r <= acc + din_ext;
          sum_v <= 1'b1;
        end
      end
    end
  end

  assign pop  = dec_valid && dec_ready;
  assign drop = res_v && full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clear_ovf) begin
      ovf <= 1'b0;
    end
  end

  fir_out_fifo #(
    .D_W        (D_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (res_v),
    .wdata (res_r),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign dec_valid = !empty;
  assign dec_out   = empty ? '0 : head;

endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage directly downstream of `fir_top`. It consumes the filter's signed sample stream and decimates it by an integer power of two using integrate-and-dump averaging with round-half-up. Results are buffered in a small show-ahead FIFO and presented on a valid/ready interface to the next consumer. Dropped results on FIFO overflow are flagged by a sticky status bit.

## Interface
- `D_W`, 12: sample width. Input and output are two's complement.
- `LOG2_DECIM`, 2: log2 of the decimation factor. DECIM = 2**LOG2_DECIM, and LOG2_DECIM ≥ 1.
- `FIFO_DEPTH`, 4: number of output FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clock`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `dec_in`  in  D_W signed: sample from `fir_out`.
- `in_valid`  in  1: `dec_in` is valid this cycle. Tied high when fed by `fir_top`.
- `dec_out`  out  D_W signed: FIFO head value. Driven 0 when `dec_valid` is low.
- `dec_valid`  out  1: FIFO is non-empty.
- `dec_ready`  in  1: consumer accepts the head this cycle.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1): number of occupied entries.
- `ovf`  out  1: sticky flag, set when a result is dropped.
- `clear_ovf`  in  1: clears `ovf`.

## Operation
- **Phase counter** (0..DECIM-1):
  - Increments on each edge with `in_valid`=1.
  - Wraps from DECIM-1 to 0.
  - Holds when `in_valid`=0.
- **Accumulator** (width D_W+LOG2_DECIM, signed):
  - Phase 0 with `in_valid`: acc ← sext(`dec_in`). This is the dump.
  - Other phases with `in_valid`: acc ← acc + sext(`dec_in`).
  - No overflow is possible at this width.
- **Dump stage**:
  - On the edge accepting the phase DECIM-1 sample, the complete sum is registered as `sum_r`.
  - `sum_v` is set for one cycle.
- **Round stage**:
  - res = (sum_r + 2**(LOG2_DECIM-1)) >>> LOG2_DECIM, using arithmetic shift (round half toward +∞).
  - The result always fits D_W, so no saturation logic is needed.
  - Registered as `res_r` with a one-cycle `res_v`.
- **FIFO push/pop**:
  - `res_v`=1 pushes `res_r`.
  - Pop occurs when `dec_valid` && `dec_ready`.
- **Full FIFO**:
  - Push with simultaneous pop: both take effect and the level is unchanged.
  - Push without pop: the result is discarded, contents are unchanged, and `ovf` ← 1.
- **`ovf` control**:
  - `clear_ovf` clears `ovf`.
  - A drop in the same cycle as `clear_ovf` wins, so `ovf` stays 1.
- **Empty FIFO**:
  - `dec_ready` is ignored.
  - A push and a pop cannot coincide.
- **Reset values**: phase 0, acc 0, `sum_v`/`res_v` 0, FIFO empty, `dec_valid` 0, `dec_out` 0, `fifo_level` 0, `ovf` 0.
- **Reset mid-operation**:
  - Partial accumulation and all FIFO contents are discarded.
  - The first sample after reset deasserts is phase 0.

## Timing
- **Latency**: last sample of a group accepted at edge k, then `sum_r` at k, `res_r` at k+1, FIFO write at k+2.
  - `dec_valid` is high after edge k+2 if the FIFO was empty.
  - Fixed 2-cycle latency from last-sample edge to visibility.
- **Throughput**: one result per DECIM accepted samples. With `in_valid` tied high, one result every DECIM cycles.
- **Head stability**: `dec_out` and `dec_valid` are registered/FIFO-driven, with no combinational path from `dec_ready`. The head is stable until popped.
- **`fifo_level`**: updates on the same edge as the push/pop.
- **`in_valid` gaps**: stall phase progress only. The pipeline stages still advance.

## Structure
- Package `fir_pkg`:
  - Default D_W constant (12).
  - `sample_t` typedef (logic signed [D_W-1:0]).
  - Rounding-offset helper function.
  - The package is shared with `fir_top`.
- Sub-module `fir_out_fifo`:
  - Parameterized D_W/FIFO_DEPTH show-ahead FIFO.
  - Wrap-around read/write pointers with an extra MSB for full/empty.
  - Ports for push, pop, full, empty and level.
- All accumulation/round logic and `ovf` live in `fir_decim_out`.

## Test plan
All tests use defaults (D_W=12, DECIM=4) unless noted.
- **Impulse**: reset, then `dec_in` 0x7FF for one cycle followed by zeros, `dec_ready`=1.
  - First result is 512 ((2047+2)>>>2).
  - All later results are 0.
- **Full-scale constants**: constant 0x7FF gives 2047. Constant 0x800 (-2048) gives -2048. No wrap.
- **Negative rounding**:
  - Group {-1,-1,-1,-1} gives -1.
  - Group {-2,0,0,0} gives 0.
  - Group {-3,0,0,0} gives -1.
- **Backpressure/overflow**: `dec_ready`=0, feed 5 groups of known values.
  - `fifo_level` reaches 4 and `ovf`=1.
  - Draining gives the first 4 results in order, and the 5th is lost.
  - `clear_ovf` pulse returns `ovf` to 0.
- **Full with simultaneous push+pop**: level stays 4, no `ovf`, order preserved.
- **Reset mid-group**: assert reset after 2 samples of a group.
  - `dec_valid`=0 and `fifo_level`=0 on the following edge.
  - The next result covers only the 4 post-reset samples.
- **`in_valid` gaps**: inserting random idle cycles yields identical results and order, with 2-cycle latency from each group's last valid sample.
